// File: rtl/rinse_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// washer_pkg
// Shared types and constants for the washer rinse path.
//   - rinseState_t : rinse sequencer state encoding (3 bits)
//   - DEF_*_SEC    : default step lengths in seconds
//   - REMAIN_W     : width of the whole-phase seconds-remaining counter
//   - TIMER_W      : width of the per-step down-counter
//   - effLen()     : step length with zero promoted to one second
//   - satTotal()   : rounds * per-round seconds, saturated to REMAIN_W bits
// -----------------------------------------------------------------------------
package washer_pkg;

    localparam int REMAIN_W = 8;
    localparam int TIMER_W  = 6;

    localparam int DEF_DRAIN_SEC = 3;
    localparam int DEF_SPIN_SEC  = 3;
    localparam int DEF_FILL_SEC  = 3;
    localparam int DEF_RINSE_SEC = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        SPIN  = 3'd2,
        FILL  = 3'd3,
        RINSE = 3'd4,
        DONE  = 3'd5
    } rinseState_t;

    // A zero-length step would never see timer==1, so it is run as one second.
    function automatic logic [TIMER_W-1:0] effLen(input logic [TIMER_W-1:0] len);
        logic [TIMER_W-1:0] res;
        if (len == {TIMER_W{1'b0}}) begin
            res = {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            res = len;
        end
        return res;
    endfunction

    // Whole-phase length; the product is formed wide and clamped so a long
    // configuration shows 255 rather than wrapping to a small number.
    function automatic logic [REMAIN_W-1:0] satTotal(
        input logic [1:0]         roundsEff,
        input logic [TIMER_W+1:0] roundSum
    );
        logic [TIMER_W+3:0]  prod;
        logic [REMAIN_W-1:0] res;
        prod = {2'b00, roundSum} * {8'b0000_0000, roundsEff};
        if (prod > {2'b00, 8'hFF}) begin
            res = 8'hFF;
        end else begin
            res = prod[REMAIN_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rinse_sequencer_if.sv
// -----------------------------------------------------------------------------
// rinse_sequencer_if
// Bundles the rinse sequencer's control inputs and status/actuator outputs.
//   master : the controlling side (drives start/config/lid/tick, reads status)
//   slave  : the rinse sequencer itself
// Signals:
//   start, rounds[1:0], water_lvl[1:0], lid_open, sec_tick   (master -> slave)
//   busy, done, outWater, spinOn, inWater, rinseOn, paused,
//   round_idx[1:0], remain[REMAIN_W-1:0]                      (slave -> master)
// -----------------------------------------------------------------------------
interface rinse_sequencer_if;
    import washer_pkg::*;

    logic                start;
    logic [1:0]          rounds;
    logic [1:0]          water_lvl;
    logic                lid_open;
    logic                sec_tick;

    logic                busy;
    logic                done;
    logic                outWater;
    logic                spinOn;
    logic                inWater;
    logic                rinseOn;
    logic                paused;
    logic [1:0]          round_idx;
    logic [REMAIN_W-1:0] remain;

    modport master (
        output start, rounds, water_lvl, lid_open, sec_tick,
        input  busy, done, outWater, spinOn, inWater, rinseOn, paused,
               round_idx, remain
    );

    modport slave (
        input  start, rounds, water_lvl, lid_open, sec_tick,
        output busy, done, outWater, spinOn, inWater, rinseOn, paused,
               round_idx, remain
    );

endinterface

// File: rtl/rinse_sequencer_step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Loadable down-counter that times one rinse step in counted seconds.
// Ports:
//   cp        in   clock
//   resetBtn  in   synchronous active-high reset (counter -> 0)
//   load      in   load loadVal this edge (has priority over counting)
//   loadVal   in   step length to load
//   enable    in   one counted second elapsed this cycle
//   expire    out  enable while the counter holds 1: the step ends this edge
// -----------------------------------------------------------------------------
module step_timer
    import washer_pkg::*;
(
    input  logic               cp,
    input  logic               resetBtn,
    input  logic               load,
    input  logic [TIMER_W-1:0] loadVal,
    input  logic               enable,
    output logic               expire
);

    localparam logic [TIMER_W-1:0] ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

    logic [TIMER_W-1:0] count_r;

    // Step counter: load on step entry, else count down on counted seconds.
    always_ff @(posedge cp) begin
        if (resetBtn) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (load) begin
            count_r <= loadVal;
        end else if (enable && (count_r != {TIMER_W{1'b0}})) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // The last second of a step is consumed by the state change, not by a
    // decrement to zero, so a step of N seconds spans exactly N counted ticks.
    assign expire = enable && (count_r == ONE);

endmodule

// File: rtl/rinse_sequencer.sv
// -----------------------------------------------------------------------------
// rinse_sequencer
// Runs the washer rinse phase: DRAIN -> SPIN -> FILL -> RINSE, repeated for
// 1..3 rounds, then a one-cycle DONE. Steps are timed in whole seconds from
// sec_tick; a high lid_open freezes the step timer and remain and drops all
// actuators until it is released.
// Ports:
//   cp        in   system clock
//   resetBtn  in   synchronous active-high reset (aborts without done)
//   bus       slave side of rinse_sequencer_if:
//     start, rounds, water_lvl, lid_open, sec_tick   inputs
//     busy, done, outWater, spinOn, inWater, rinseOn,
//     paused, round_idx, remain                       registered outputs
// -----------------------------------------------------------------------------
module rinse_sequencer
    import washer_pkg::*;
#(
    parameter int DRAIN_SEC = DEF_DRAIN_SEC,
    parameter int SPIN_SEC  = DEF_SPIN_SEC,
    parameter int FILL_SEC  = DEF_FILL_SEC,
    parameter int RINSE_SEC = DEF_RINSE_SEC
) (
    input  logic cp,
    input  logic resetBtn,
    rinse_sequencer_if.slave bus
);

    localparam logic [TIMER_W-1:0] DRAIN_LEN = effLen(TIMER_W'(DRAIN_SEC));
    localparam logic [TIMER_W-1:0] SPIN_LEN  = effLen(TIMER_W'(SPIN_SEC));
    localparam logic [TIMER_W-1:0] RINSE_LEN = effLen(TIMER_W'(RINSE_SEC));
    localparam logic [TIMER_W-1:0] FILL_BASE = TIMER_W'(FILL_SEC);

    rinseState_t          state_r;
    rinseState_t          nextState_s;

    logic [1:0]           roundsEff_r;
    logic [TIMER_W-1:0]   fillLen_r;
    logic [1:0]           roundIdx_r;
    logic [REMAIN_W-1:0]  remain_r;

    logic                 busy_r;
    logic                 done_r;
    logic                 outWater_r;
    logic                 spinOn_r;
    logic                 inWater_r;
    logic                 rinseOn_r;
    logic                 paused_r;

    logic                 active_s;
    logic                 countedTick_s;
    logic                 startAcc_s;
    logic [1:0]           startRoundsEff_s;
    logic [TIMER_W-1:0]   startFill_s;
    logic [TIMER_W+1:0]   startSum_s;
    logic [REMAIN_W-1:0]  startTotal_s;
    logic [2:0]           roundNext_s;
    logic                 lastRound_s;
    logic                 expire_s;
    logic                 timerLoad_s;
    logic [TIMER_W-1:0]   timerLoadVal_s;

    step_timer u_stepTimer (
        .cp       (cp),
        .resetBtn (resetBtn),
        .load     (timerLoad_s),
        .loadVal  (timerLoadVal_s),
        .enable   (countedTick_s),
        .expire   (expire_s)
    );

    // Qualifiers and start-time configuration derived from inputs and state.
    always_comb begin
        active_s = 1'b0;
        case (state_r)
            DRAIN, SPIN, FILL, RINSE: active_s = 1'b1;
            default:                  active_s = 1'b0;
        endcase

        // Seconds only count while a step is running and the lid is shut.
        countedTick_s = active_s && bus.sec_tick && !bus.lid_open;
        startAcc_s    = (state_r == IDLE) && bus.start;

        if (bus.rounds == 2'd0) begin
            startRoundsEff_s = 2'd1;
        end else begin
            startRoundsEff_s = bus.rounds;
        end

        startFill_s  = effLen(FILL_BASE + {{(TIMER_W-2){1'b0}}, bus.water_lvl});
        startSum_s   = {2'b00, DRAIN_LEN} + {2'b00, SPIN_LEN}
                     + {2'b00, startFill_s} + {2'b00, RINSE_LEN};
        startTotal_s = satTotal(startRoundsEff_s, startSum_s);

        roundNext_s  = {1'b0, roundIdx_r} + 3'd1;
        lastRound_s  = (roundNext_s >= {1'b0, roundsEff_r});
    end

    // Next-state decode; also picks the step length loaded on step entry.
    always_comb begin
        nextState_s    = state_r;
        timerLoad_s    = 1'b0;
        timerLoadVal_s = {TIMER_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (startAcc_s) begin
                    nextState_s    = DRAIN;
                    timerLoad_s    = 1'b1;
                    timerLoadVal_s = DRAIN_LEN;
                end else begin
                    nextState_s    = IDLE;
                end
            end
            DRAIN: begin
                if (expire_s) begin
                    nextState_s    = SPIN;
                    timerLoad_s    = 1'b1;
                    timerLoadVal_s = SPIN_LEN;
                end else begin
                    nextState_s    = DRAIN;
                end
            end
            SPIN: begin
                if (expire_s) begin
                    nextState_s    = FILL;
                    timerLoad_s    = 1'b1;
                    timerLoadVal_s = fillLen_r;
                end else begin
                    nextState_s    = SPIN;
                end
            end
            FILL: begin
                if (expire_s) begin
                    nextState_s    = RINSE;
                    timerLoad_s    = 1'b1;
                    timerLoadVal_s = RINSE_LEN;
                end else begin
                    nextState_s    = FILL;
                end
            end
            RINSE: begin
                if (expire_s && lastRound_s) begin
                    nextState_s    = DONE;
                    timerLoad_s    = 1'b1;
                    timerLoadVal_s = {TIMER_W{1'b0}};
                end else if (expire_s) begin
                    nextState_s    = DRAIN;
                    timerLoad_s    = 1'b1;
                    timerLoadVal_s = DRAIN_LEN;
                end else begin
                    nextState_s    = RINSE;
                end
            end
            DONE: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge cp) begin
        if (resetBtn) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Phase context: configuration latched at start, round index, remain.
    always_ff @(posedge cp) begin
        if (resetBtn) begin
            roundsEff_r <= 2'd0;
            fillLen_r   <= {TIMER_W{1'b0}};
            roundIdx_r  <= 2'd0;
            remain_r    <= {REMAIN_W{1'b0}};
        end else if (startAcc_s) begin
            roundsEff_r <= startRoundsEff_s;
            fillLen_r   <= startFill_s;
            roundIdx_r  <= 2'd0;
            remain_r    <= startTotal_s;
        end else begin
            roundsEff_r <= roundsEff_r;
            fillLen_r   <= fillLen_r;
            if ((state_r == RINSE) && expire_s && !lastRound_s) begin
                roundIdx_r <= roundNext_s[1:0];
            end else begin
                roundIdx_r <= roundIdx_r;
            end
            // DONE always shows zero, even if saturation left seconds over.
            if (nextState_s == DONE) begin
                remain_r <= {REMAIN_W{1'b0}};
            end else if (countedTick_s && (remain_r != {REMAIN_W{1'b0}})) begin
                remain_r <= remain_r - {{(REMAIN_W-1){1'b0}}, 1'b1};
            end else begin
                remain_r <= remain_r;
            end
        end
    end

    // Output flags decoded from the next state so they switch with the state.
    always_ff @(posedge cp) begin
        if (resetBtn) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            outWater_r <= 1'b0;
            spinOn_r   <= 1'b0;
            inWater_r  <= 1'b0;
            rinseOn_r  <= 1'b0;
            paused_r   <= 1'b0;
        end else begin
            busy_r     <= (nextState_s != IDLE);
            done_r     <= (nextState_s == DONE);
            outWater_r <= (nextState_s == DRAIN) && !bus.lid_open;
            spinOn_r   <= (nextState_s == SPIN)  && !bus.lid_open;
            inWater_r  <= (nextState_s == FILL)  && !bus.lid_open;
            rinseOn_r  <= (nextState_s == RINSE) && !bus.lid_open;
            paused_r   <= (nextState_s != IDLE)  && bus.lid_open;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.outWater  = outWater_r;
    assign bus.spinOn    = spinOn_r;
    assign bus.inWater   = inWater_r;
    assign bus.rinseOn   = rinseOn_r;
    assign bus.paused    = paused_r;
    assign bus.round_idx = roundIdx_r;
    assign bus.remain    = remain_r;

endmodule

// File: tb/tb_rinse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rinse_sequencer
// Directed scenarios for rinse_sequencer. Each scenario pushes the expected
// output changes ({paused,outWater,spinOn,inWater,rinseOn} with tick count,
// remain and round) and expected done tick counts into queues; a monitor
// compares every observed change or done pulse against the queue head.
// -----------------------------------------------------------------------------
module tb_rinse_sequencer;

    logic cp;
    logic resetBtn;

    rinse_sequencer_if bus ();

    rinse_sequencer dut (
        .cp       (cp),
        .resetBtn (resetBtn),
        .bus      (bus)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        logic [4:0] vec;
        int         ticks;
        int         rem;
        int         rnd;
    } ev_t;

    ev_t evQ[$];
    int  doneQ[$];

    int  checks = 0;
    int  errors = 0;
    bit  monOn  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushEv(input logic [4:0] vec, input int ticks, input int rem, input int rnd);
        ev_t e;
        e.vec = vec; e.ticks = ticks; e.rem = rem; e.rnd = rnd;
        evQ.push_back(e);
    endtask

    // Standard single-round expectations for DRAIN 3, SPIN 3, FILL 3, RINSE 5.
    task automatic pushOneRound();
        pushEv(5'b01000, 0, 14, 0);
        pushEv(5'b00100, 3, 11, 0);
        pushEv(5'b00010, 6, 8, 0);
        pushEv(5'b00001, 9, 5, 0);
        pushEv(5'b00000, 14, 0, 0);
        doneQ.push_back(14);
    endtask

    task automatic startSeq(input logic [1:0] r, input logic [1:0] w);
        @(negedge cp);
        bus.rounds    = r;
        bus.water_lvl = w;
        bus.start     = 1'b1;
        @(negedge cp);
        bus.start     = 1'b0;
    endtask

    task automatic runTicks(input int n);
        repeat (n) begin
            @(negedge cp);
            bus.sec_tick = 1'b1;
            @(negedge cp);
            bus.sec_tick = 1'b0;
            repeat (2) @(negedge cp);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (bus.busy && (n < 10)) begin
            @(negedge cp);
            n++;
        end
        check("back_to_idle", int'(bus.busy), 0);
    endtask

    // Monitor: samples just after each rising edge, while the inputs that
    // edge sampled are still applied.
    initial begin : monitor
        logic [4:0] v;
        logic [4:0] prevVec;
        logic       prevLid;
        logic       prevBusy;
        logic       cause;
        int         tickCnt;
        int         base;
        ev_t        e;
        tickCnt = 0;
        base    = 0;
        wait (monOn);
        prevVec  = {bus.paused, bus.outWater, bus.spinOn, bus.inWater, bus.rinseOn};
        prevLid  = bus.lid_open;
        prevBusy = bus.busy;
        forever begin
            @(posedge cp);
            #1;
            if (bus.sec_tick) tickCnt++;
            if (bus.start && !prevBusy && !resetBtn) base = tickCnt;
            v = {bus.paused, bus.outWater, bus.spinOn, bus.inWater, bus.rinseOn};
            if (v != prevVec) begin
                cause = bus.sec_tick || bus.start || resetBtn || (bus.lid_open != prevLid);
                check("change_on_stimulus_edge", int'(cause), 1);
                if (evQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got %b expected no change", v);
                end else begin
                    e = evQ.pop_front();
                    check("flags", int'(v), int'(e.vec));
                    check("ticks_at_change", tickCnt - base, e.ticks);
                    check("remain_at_change", int'(bus.remain), e.rem);
                    check("round_at_change", int'(bus.round_idx), e.rnd);
                end
            end
            if (bus.done) begin
                if (doneQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    check("ticks_at_done", tickCnt - base, doneQ.pop_front());
                    check("done_on_tick_edge", int'(bus.sec_tick), 1);
                    check("busy_at_done", int'(bus.busy), 1);
                    check("remain_at_done", int'(bus.remain), 0);
                    check("flags_at_done", int'(v), 0);
                end
            end
            prevVec  = v;
            prevLid  = bus.lid_open;
            prevBusy = bus.busy;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.start     = 1'b0;
        bus.rounds    = 2'd0;
        bus.water_lvl = 2'd0;
        bus.lid_open  = 1'b0;
        bus.sec_tick  = 1'b0;
        resetBtn      = 1'b1;
        repeat (3) @(negedge cp);
        // start coinciding with reset must be dropped
        bus.rounds = 2'd1;
        bus.start  = 1'b1;
        @(negedge cp);
        bus.start  = 1'b0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_remain", int'(bus.remain), 0);
        check("rst_round", int'(bus.round_idx), 0);
        check("rst_flags", int'({bus.paused, bus.outWater, bus.spinOn, bus.inWater, bus.rinseOn}), 0);
        resetBtn = 1'b0;
        monOn    = 1'b1;
        repeat (2) @(negedge cp);
        check("idle_after_rst", int'(bus.busy), 0);

        // 1: one round, no extra water
        pushOneRound();
        startSeq(2'd1, 2'd0);
        runTicks(14);
        waitIdle();

        // 2: three rounds, water_lvl 2 -> 16 s per round, 48 total
        for (int r = 0; r < 3; r++) begin
            pushEv(5'b01000, 16*r,      48 - 16*r,        r);
            pushEv(5'b00100, 16*r + 3,  48 - 16*r - 3,    r);
            pushEv(5'b00010, 16*r + 6,  48 - 16*r - 6,    r);
            pushEv(5'b00001, 16*r + 11, 48 - 16*r - 11,   r);
        end
        pushEv(5'b00000, 48, 0, 2);
        doneQ.push_back(48);
        startSeq(2'd3, 2'd2);
        runTicks(48);
        waitIdle();

        // 3: rounds=0 runs one round
        pushOneRound();
        startSeq(2'd0, 2'd0);
        runTicks(14);
        waitIdle();

        // 4: lid open for 10 cycles in SPIN with two ticks inside
        pushEv(5'b01000, 0, 14, 0);
        pushEv(5'b00100, 3, 11, 0);
        pushEv(5'b10000, 4, 10, 0);
        pushEv(5'b00100, 6, 10, 0);
        pushEv(5'b00010, 8, 8, 0);
        pushEv(5'b00001, 11, 5, 0);
        pushEv(5'b00000, 16, 0, 0);
        doneQ.push_back(16);
        startSeq(2'd1, 2'd0);
        runTicks(4);
        @(negedge cp);
        bus.lid_open = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.sec_tick = ((c == 1) || (c == 5));
            @(negedge cp);
        end
        bus.sec_tick = 1'b0;
        bus.lid_open = 1'b0;
        runTicks(10);
        waitIdle();

        // 5: second start during FILL with different config is ignored
        pushOneRound();
        startSeq(2'd1, 2'd0);
        runTicks(7);
        startSeq(2'd3, 2'd3);
        check("busy_after_ignored_start", int'(bus.busy), 1);
        runTicks(7);
        waitIdle();

        // 6: reset during RINSE of round 1 (two rounds, 28 s total)
        pushEv(5'b01000, 0, 28, 0);
        pushEv(5'b00100, 3, 25, 0);
        pushEv(5'b00010, 6, 22, 0);
        pushEv(5'b00001, 9, 19, 0);
        pushEv(5'b01000, 14, 14, 1);
        pushEv(5'b00100, 17, 11, 1);
        pushEv(5'b00010, 20, 8, 1);
        pushEv(5'b00001, 23, 5, 1);
        pushEv(5'b00000, 24, 0, 0);
        startSeq(2'd2, 2'd0);
        runTicks(24);
        @(negedge cp);
        resetBtn = 1'b1;
        @(negedge cp);
        resetBtn = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_remain", int'(bus.remain), 0);
        check("abort_round", int'(bus.round_idx), 0);
        repeat (4) @(negedge cp);

        // full run after the abort
        pushOneRound();
        startSeq(2'd1, 2'd0);
        runTicks(14);
        waitIdle();

        repeat (4) @(negedge cp);
        check("events_consumed", evQ.size(), 0);
        check("dones_consumed", doneQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
